// File: rtl/pll_reset_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer_pkg
//   Shared definitions for the PLL reset sequencer: sequencer state encoding,
//   relock counter width and a counter-width helper.
// ----------------------------------------------------------------------------
package pll_reset_sequencer_pkg;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_WAIT  = 2'd1,
      S_RUN   = 2'd2
   } seq_state_t;

   localparam int unsigned RELOCK_W = 8;

   // Bits needed to hold 0..max_count-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// ----------------------------------------------------------------------------
// sync_bit_2ff
//   Two-flop synchronizer for a single asynchronous level, with synchronous
//   active-high reset clearing both stages.
// Ports:
//   clk      destination clock
//   reset_p  synchronous active-high reset
//   d        asynchronous input
//   q        synchronized output (2 cycles latency)
// ----------------------------------------------------------------------------
module sync_bit_2ff (
   input  logic clk,
   input  logic reset_p,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset_p) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
//   Holds the iCE40 PLL in reset, waits for a stable LOCK, then releases a
//   synchronous reset to downstream logic. On lock loss the PLL is reset and
//   locking is retried; a lock that never arrives times out and retries.
//   Runs on the reference oscillator clock.
// Ports:
//   clk            reference oscillator clock
//   reset_p        synchronous active-high reset
//   pll_lock       PLL LOCK output (asynchronous)
//   pll_resetb     PLL RESET, active low
//   out_reset_p    downstream reset, active high
//   status_locked  high while running
//   relock_count   lock losses seen while running, saturating
//   fault_strobe   one-cycle pulse on each lock-wait timeout
// Build option:
//   PLL_SEQ_DROP_FILTER_EN  require DROP_CYCLES consecutive low lock samples
//                           before a running sequencer treats lock as lost
// ----------------------------------------------------------------------------
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 12,
   parameter int unsigned LOCK_FILTER  = 1200,
   parameter int unsigned LOCK_TIMEOUT = 120000,
   parameter int unsigned DROP_CYCLES  = 4
) (
   input  logic                clk,
   input  logic                reset_p,
   input  logic                pll_lock,
   output logic                pll_resetb,
   output logic                out_reset_p,
   output logic                status_locked,
   output logic [RELOCK_W-1:0] relock_count,
   output logic                fault_strobe
);

   localparam int unsigned RST_W  = cnt_width(RESET_CYCLES);
   localparam int unsigned FILT_W = cnt_width(LOCK_FILTER);
   localparam int unsigned TMO_W  = cnt_width(LOCK_TIMEOUT);

   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

   if (RESET_CYCLES == 0 || LOCK_FILTER == 0 || DROP_CYCLES == 0 ||
       LOCK_TIMEOUT <= LOCK_FILTER) begin : g_param_check
      $error("pll_reset_sequencer: invalid parameter set");
   end

   seq_state_t          state_q, state_d;
   logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
   logic [FILT_W-1:0]   filt_q, filt_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [RELOCK_W-1:0] relock_d;
   logic                fault_d;
   logic                lost;
   logic                lock_s;

`ifdef PLL_SEQ_DROP_FILTER_EN
   localparam int unsigned        DROP_W    = cnt_width(DROP_CYCLES);
   localparam logic [DROP_W-1:0]  DROP_LAST = DROP_W'(DROP_CYCLES - 1);
   logic [DROP_W-1:0]             drop_q, drop_d;
`endif

   sync_bit_2ff u_lock_sync (
      .clk     (clk),
      .reset_p (reset_p),
      .d       (pll_lock),
      .q       (lock_s)
   );

   // Counters default to zero so each one starts cleared on state entry.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = '0;
      filt_d    = '0;
      tmo_d     = '0;
`ifdef PLL_SEQ_DROP_FILTER_EN
      drop_d    = '0;
`endif
      fault_d   = 1'b0;
      relock_d  = relock_count;
      lost      = 1'b0;

      case (state_q)
         S_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = S_WAIT;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end

         S_WAIT: begin
            // A lock qualifying on the timeout cycle takes priority.
            if (lock_s && (filt_q == FILT_LAST)) begin
               state_d = S_RUN;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_RESET;
               fault_d = 1'b1;
            end else begin
               tmo_d  = tmo_q + TMO_W'(1);
               filt_d = lock_s ? filt_q + FILT_W'(1) : '0;
            end
         end

         S_RUN: begin
`ifdef PLL_SEQ_DROP_FILTER_EN
            if (!lock_s) begin
               if (drop_q == DROP_LAST) begin
                  lost = 1'b1;
               end else begin
                  drop_d = drop_q + DROP_W'(1);
               end
            end
`else
            lost = !lock_s;
`endif
            if (lost) begin
               state_d = S_RESET;
               if (relock_count != '1) begin
                  relock_d = relock_count + RELOCK_W'(1);
               end
            end
         end

         default: state_d = S_RESET;
      endcase
   end

   // Outputs are registered from the next state so they change on the same
   // edge as the state they describe.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_q       <= S_RESET;
         rst_cnt_q     <= '0;
         filt_q        <= '0;
         tmo_q         <= '0;
`ifdef PLL_SEQ_DROP_FILTER_EN
         drop_q        <= '0;
`endif
         pll_resetb    <= 1'b0;
         out_reset_p   <= 1'b1;
         status_locked <= 1'b0;
         relock_count  <= '0;
         fault_strobe  <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         filt_q        <= filt_d;
         tmo_q         <= tmo_d;
`ifdef PLL_SEQ_DROP_FILTER_EN
         drop_q        <= drop_d;
`endif
         pll_resetb    <= (state_d != S_RESET);
         out_reset_p   <= (state_d != S_RUN);
         status_locked <= (state_d == S_RUN);
         relock_count  <= relock_d;
         fault_strobe  <= fault_d;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

   localparam int RC = 4;
   localparam int LF = 8;
   localparam int LT = 50;
`ifdef PLL_SEQ_DROP_FILTER_EN
   localparam int DROP_NEED = 4;
`else
   localparam int DROP_NEED = 1;
`endif

   logic       clk;
   logic       reset_p;
   logic       pll_lock;
   logic       pll_resetb;
   logic       out_reset_p;
   logic       status_locked;
   logic [7:0] relock_count;
   logic       fault_strobe;

   pll_reset_sequencer #(
      .RESET_CYCLES (RC),
      .LOCK_FILTER  (LF),
      .LOCK_TIMEOUT (LT),
      .DROP_CYCLES  (4)
   ) dut (
      .clk           (clk),
      .reset_p       (reset_p),
      .pll_lock      (pll_lock),
      .pll_resetb    (pll_resetb),
      .out_reset_p   (out_reset_p),
      .status_locked (status_locked),
      .relock_count  (relock_count),
      .fault_strobe  (fault_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: PLL-reset countdown, lock-wait age and lock streak,
   // running flag with a low-sample run, plus the raw lock sample history
   // (two samples ago is what the sequencer sees).
   int   m_hold;
   bit   m_locked;
   int   m_age, m_streak, m_drops, m_relocks;
   bit   m_fault;
   logic hist[$];

   task automatic model_edge(input logic r, input logic l);
      logic ls;
      if (r) begin
         m_hold = RC; m_locked = 0; m_age = 0; m_streak = 0;
         m_drops = 0; m_relocks = 0; m_fault = 0;
         hist = '{1'b0, 1'b0};
      end else begin
         ls = hist[0];
         m_fault = 0;
         if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin m_age = 0; m_streak = 0; end
         end else if (!m_locked) begin
            m_streak = ls ? m_streak + 1 : 0;
            m_age++;
            if (m_streak == LF) begin
               m_locked = 1; m_drops = 0;
            end else if (m_age == LT) begin
               m_hold = RC; m_fault = 1;
            end
         end else begin
            m_drops = ls ? 0 : m_drops + 1;
            if (m_drops >= DROP_NEED) begin
               m_locked = 0; m_hold = RC;
               if (m_relocks < 255) m_relocks++;
            end
         end
         void'(hist.pop_front());
         hist.push_back(l);
      end
   endtask

   task automatic step(input logic r, input logic l);
      @(negedge clk);
      reset_p  = r;
      pll_lock = l;
      @(posedge clk);
      model_edge(r, l);
      #1;
      chk("model.pll_resetb",    32'(pll_resetb),    32'(m_hold == 0));
      chk("model.out_reset_p",   32'(out_reset_p),   32'(!m_locked));
      chk("model.status_locked", 32'(status_locked), 32'(m_locked));
      chk("model.relock_count",  32'(relock_count),  32'(m_relocks));
      chk("model.fault_strobe",  32'(fault_strobe),  32'(m_fault));
   endtask

   typedef struct {
      logic        r;
      logic        l;
      int unsigned n;
      logic        e_resetb;
      logic        e_orst;
      logic        e_locked;
      logic [7:0]  e_rc;
      logic        e_fault;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic l, input int unsigned n,
                      input logic rb, input logic orst, input logic lk,
                      input logic [7:0] rcnt, input logic f);
      vec_t v;
      v.r = r; v.l = l; v.n = n; v.e_resetb = rb; v.e_orst = orst;
      v.e_locked = lk; v.e_rc = rcnt; v.e_fault = f;
      tbl.push_back(v);
   endtask

   task automatic run_table();
      for (int i = 0; i < tbl.size(); i++) begin
         for (int unsigned k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].l);
         chk($sformatf("tbl[%0d].pll_resetb", i),    32'(pll_resetb),    32'(tbl[i].e_resetb));
         chk($sformatf("tbl[%0d].out_reset_p", i),   32'(out_reset_p),   32'(tbl[i].e_orst));
         chk($sformatf("tbl[%0d].status_locked", i), 32'(status_locked), 32'(tbl[i].e_locked));
         chk($sformatf("tbl[%0d].relock_count", i),  32'(relock_count),  32'(tbl[i].e_rc));
         chk($sformatf("tbl[%0d].fault_strobe", i),  32'(fault_strobe),  32'(tbl[i].e_fault));
      end
   endtask

   task automatic seq_first_lock();
      int lowcnt;
      int first;
      step(1, 0); step(1, 0);
      lowcnt = (pll_resetb == 1'b0) ? 1 : 0;
      for (int i = 1; i <= 9; i++) begin
         step(0, 0);
         if (!pll_resetb) lowcnt++;
      end
      chk("resetb_low_cycles", 32'(lowcnt), 32'(RC));
      first = -1;
      for (int i = 10; i < 60 && first < 0; i++) begin
         step(0, 1);
         if (!out_reset_p) first = i;
      end
      if (first < 0) begin
         chk("release_timeout", 32'(0), 32'(1));
      end else begin
         chk("lock_to_release", 32'(first - 10 + 1), 32'(2 + LF));
         chk("locked_with_release", 32'(status_locked), 32'(1));
      end
   endtask

   task automatic seq_toggle();
      int faults;
      bit released;
      faults = 0; released = 0;
      step(1, 0); step(1, 0);
      for (int i = 0; i < 300; i++) begin
         step(0, (i % 8) != 7);
         if (!out_reset_p) released = 1;
         if (fault_strobe) faults++;
      end
      chk("toggle_never_released", 32'(released), 32'(0));
      chk("toggle_retries_seen", 32'(faults > 0), 32'(1));
      chk("toggle_relock_zero", 32'(relock_count), 32'(0));
   endtask

   task automatic seq_saturate();
      int budget;
      bit stuck;
      stuck = 0;
      step(1, 0); step(1, 0);
      for (int n = 0; n < 260 && !stuck; n++) begin
         budget = 0;
         while (!status_locked && budget < 200) begin step(0, 1); budget++; end
         if (!status_locked) begin
            chk("saturate_lock_wait", 32'(0), 32'(1));
            stuck = 1;
         end else begin
            for (int k = 0; k < DROP_NEED; k++) step(0, 0);
            budget = 0;
            while (status_locked && budget < 20) begin step(0, 1); budget++; end
         end
      end
      chk("relock_saturated", 32'(relock_count), 32'(255));
   endtask

   task automatic seq_random();
      int   seg;
      logic lvl;
      seg = 0; lvl = 0;
      step(1, 0); step(1, 0);
      for (int i = 0; i < 4000; i++) begin
         if (seg == 0) begin
            lvl = ($urandom_range(0, 3) != 0);
            seg = lvl ? $urandom_range(1, 40) : $urandom_range(1, 6);
         end
         seg--;
         step(($urandom_range(0, 599) == 0), lvl);
      end
   endtask

   initial begin
      reset_p  = 1'b1;
      pll_lock = 1'b0;

      // Lock held low: retries every RC+LT cycles, relock_count unchanged.
      add(1, 0, 2,  0, 1, 0, 0, 0);
      add(0, 0, 3,  0, 1, 0, 0, 0);
      add(0, 0, 1,  1, 1, 0, 0, 0);
      add(0, 0, 49, 1, 1, 0, 0, 0);
      add(0, 0, 1,  0, 1, 0, 0, 1);
      add(0, 0, 1,  0, 1, 0, 0, 0);
      add(0, 0, 3,  1, 1, 0, 0, 0);
      add(0, 0, 49, 1, 1, 0, 0, 0);
      add(0, 0, 1,  0, 1, 0, 0, 1);
      // Lock from step 10, release at step 19, then a one-sample drop.
      add(1, 0, 2,  0, 1, 0, 0, 0);
      add(0, 0, 9,  1, 1, 0, 0, 0);
      add(0, 1, 9,  1, 1, 0, 0, 0);
      add(0, 1, 1,  1, 0, 1, 0, 0);
      add(0, 0, 1,  1, 0, 1, 0, 0);
      add(0, 1, 1,  1, 0, 1, 0, 0);
`ifdef PLL_SEQ_DROP_FILTER_EN
      add(0, 1, 1,  1, 0, 1, 0, 0);
      add(0, 0, 4,  1, 0, 1, 0, 0);
      add(0, 1, 1,  1, 0, 1, 0, 0);
      add(0, 1, 1,  0, 1, 0, 1, 0);
      add(0, 1, 4,  1, 1, 0, 1, 0);
      add(0, 1, 7,  1, 1, 0, 1, 0);
      add(0, 1, 1,  1, 0, 1, 1, 0);
`else
      add(0, 1, 1,  0, 1, 0, 1, 0);
      add(0, 1, 4,  1, 1, 0, 1, 0);
      add(0, 1, 7,  1, 1, 0, 1, 0);
      add(0, 1, 1,  1, 0, 1, 1, 0);
`endif
      // reset_p while running.
      add(1, 1, 1,  0, 1, 0, 0, 0);

      run_table();
      seq_first_lock();
      seq_toggle();
      seq_saturate();
      seq_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
